load_store_controller: RTL and testbench

- Multi-cycle sequencer between the MIPS core and the word-addressed, Avalon-style data memory bus for all load/store instructions.
- Computes the effective address as base + sign-extended offset and checks alignment.
- Drives one bus transaction, holding it through waitrequest, then returns byte/halfword/word-formatted load data with a one-cycle done pulse.
- Owns the memory port so the core issues one start and waits for done.

---
 rtl/load_store_controller.sv | 192 +++++++++++++++++++
 tb/tb_load_store_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_controller.sv
// rtl/load_store_controller.sv - MIPS load/store sequencer for a word-addressed Avalon-style data bus
module load_store_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] base,
  input  logic [15:0] itype_immediate,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_error,
  output logic        bus_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic [1:0]  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  logic [31:0] new_ea;
  logic        new_valid;
  logic        new_misaligned;
  logic        is_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  // Decode the incoming request: effective address, legality and alignment
  always_comb begin
    new_ea         = base + {{16{itype_immediate[15]}}, itype_immediate};
    new_valid      = 1'b0;
    new_misaligned = 1'b0;
    case (opcode)
      OP_LB, OP_LBU, OP_SB: new_valid = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        new_valid      = 1'b1;
        new_misaligned = new_ea[0];
      end
      OP_LW, OP_SW: begin
        new_valid      = 1'b1;
        new_misaligned = |new_ea[1:0];
      end
      default: ;
    endcase
  end

  // Bus lane enables and replicated store data from the latched request
  always_comb begin
    is_store   = 1'b0;
    byteenable = 4'b0000;
    writedata  = 32'd0;
    case (op_q)
      OP_LB, OP_LBU: byteenable = 4'b0001 << ea_q[1:0];
      OP_LH, OP_LHU: byteenable = ea_q[1] ? 4'b1100 : 4'b0011;
      OP_LW:         byteenable = 4'b1111;
      OP_SB: begin
        is_store   = 1'b1;
        byteenable = 4'b0001 << ea_q[1:0];
        writedata  = {4{sdata_q[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        byteenable = ea_q[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{sdata_q[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        byteenable = 4'b1111;
        writedata  = sdata_q;
      end
      default: ;
    endcase
  end

  // Lane selection and sign/zero extension of the returned word
  always_comb begin
    case (ea_q[1:0])
      2'd0:    byte_sel = readdata[7:0];
      2'd1:    byte_sel = readdata[15:8];
      2'd2:    byte_sel = readdata[23:16];
      default: byte_sel = readdata[31:24];
    endcase
    half_sel = ea_q[1] ? readdata[31:16] : readdata[15:0];
    case (op_q)
      OP_LB:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_fmt = {24'd0, byte_sel};
      OP_LH:   load_fmt = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_fmt = {16'd0, half_sel};
      default: load_fmt = readdata;
    endcase
  end

  // Sequencer next-state: accept in IDLE, hold the bus in REQ, pulse in DONE
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ea_d        = ea_q;
    sdata_d     = sdata_q;
    wait_cnt_d  = wait_cnt_q;
    load_data_d = load_data_q;
    addr_err_d  = addr_err_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (start && new_valid) begin
          op_d       = opcode;
          ea_d       = new_ea;
          sdata_d    = store_data;
          wait_cnt_d = 32'd0;
          addr_err_d = new_misaligned;
          bus_err_d  = 1'b0;
          state_d    = new_misaligned ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (!waitrequest) begin
          if (!is_store) load_data_d = load_fmt;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_d == TIMEOUT_CYCLES)) begin
            bus_err_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 6'd0;
      ea_q        <= 32'd0;
      sdata_q     <= 32'd0;
      wait_cnt_q  <= 32'd0;
      load_data_q <= 32'd0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ea_q        <= ea_d;
      sdata_q     <= sdata_d;
      wait_cnt_q  <= wait_cnt_d;
      load_data_q <= load_data_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_error = done & addr_err_q;
  assign bus_error  = done & bus_err_q;
  assign read       = (state_q == S_REQ) & ~is_store;
  assign write      = (state_q == S_REQ) & is_store;
  assign address    = {ea_q[31:2], 2'b00};
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_controller.sv
// tb/tb_load_store_controller.sv - randomized scoreboard bench for load_store_controller
module tb_load_store_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] base = 32'd0;
  logic [15:0] itype_immediate = 16'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, addr_error, bus_error, read, write;
  logic [31:0] load_data, address, writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'd0;
  logic        waitrequest = 1'b0;

  always #5 clk = ~clk;

  load_store_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .base(base),
    .itype_immediate(itype_immediate), .store_data(store_data), .busy(busy),
    .done(done), .load_data(load_data), .addr_error(addr_error), .bus_error(bus_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  typedef struct {
    logic [31:0] ld;
    logic        ae;
    logic        be;
    int          lat;
    int          strobes;
    logic        is_wr;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model_ld = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21);
  endfunction

  // Issue one request, predict its outcome, and play the bus slave for it
  task automatic do_op(input logic [5:0] op, input logic [31:0] b, input logic [15:0] imm,
                       input logic [31:0] sd, input logic [31:0] rd, input int nwait, input bit spur);
    int          sz, ofs, off, k, guard;
    logic [31:0] ea, mask, v;
    exp_t        e;
    sz  = op_size(op);
    off = $signed(imm);
    ea  = b + off;
    ofs = int'(ea % 4);
    if (sz != 0) begin
      e.is_wr = op_store(op);
      e.addr  = ea - 32'(ofs);
      e.ben   = 4'(((1 << sz) - 1) << ofs);
      e.wdata = (sz == 1) ? sd[7:0] * 32'h0101_0101 : (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      e.ae    = ((ea % sz) != 0);
      e.be    = 1'b0;
      if (e.ae) begin
        e.lat = 1; e.strobes = 0;
      end else if (nwait >= TO) begin
        e.be = 1'b1; e.lat = 1 + TO; e.strobes = TO;
      end else begin
        e.lat = 2 + nwait; e.strobes = nwait + 1;
        if (!e.is_wr) begin
          mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
          v = (rd >> (8 * ofs)) & mask;
          if (op_signed(op) && v[8 * sz - 1]) v = v | ~mask;
          model_ld = v;
        end
      end
      e.ld = model_ld;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; opcode = op; base = b; itype_immediate = imm; store_data = sd;
    waitrequest = (nwait > 0);
    readdata = waitrequest ? $urandom : rd;
    @(posedge clk); #1;
    start = 1'b0; base = $urandom; itype_immediate = 16'($urandom); store_data = $urandom;
    if (sz == 0) begin
      chk("invalid_opcode_ignored", 32'(busy), 0);
      waitrequest = 1'b0;
      return;
    end
    k = 0;
    guard = 0;
    while (!done && guard < 50) begin
      @(posedge clk);
      k++;
      #1;
      waitrequest = (k < nwait);
      readdata = waitrequest ? $urandom : rd;
      start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode = 6'($urandom);
      guard++;
    end
    if (guard >= 50) chk("done_within_bound", 32'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
    waitrequest = 1'b0;
  endtask

  // Monitor: tracks bus strobes and scores every done against the queue
  int          cyc = 0, start_cyc = 0, strobes = 0;
  bit          unstable = 1'b0, prev_done = 1'b0;
  logic        saw_wr = 1'b0;
  logic [31:0] s_addr = 32'd0, s_wdata = 32'd0;
  logic [3:0]  s_ben = 4'd0;
  exp_t        mon_e;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      strobes = 0; unstable = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", 32'(busy), 0);
      prev_done = done;
      if (start && !busy) start_cyc = cyc;
      if (read || write) begin
        chk("read_write_exclusive", 32'(read & write), 0);
        if (strobes == 0) begin
          s_addr = address; s_ben = byteenable; s_wdata = writedata; saw_wr = write;
        end else if (address !== s_addr || byteenable !== s_ben || writedata !== s_wdata || write !== saw_wr) begin
          unstable = 1'b1;
        end
        strobes++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("load_data", load_data, mon_e.ld);
          chk("addr_error", 32'(addr_error), 32'(mon_e.ae));
          chk("bus_error", 32'(bus_error), 32'(mon_e.be));
          chk("latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
          chk("strobe_cycles", 32'(strobes), 32'(mon_e.strobes));
          if (mon_e.strobes > 0) begin
            chk("address", s_addr, mon_e.addr);
            chk("byteenable", 32'(s_ben), 32'(mon_e.ben));
            chk("direction", 32'(saw_wr), 32'(mon_e.is_wr));
            chk("bus_stable", 32'(unstable), 0);
            if (mon_e.is_wr) chk("writedata", s_wdata, mon_e.wdata);
          end
        end
        strobes = 0;
        unstable = 1'b0;
      end
    end
  end

  logic [5:0] op_tab [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h00};

  initial begin
    logic [5:0]  op;
    logic [31:0] b;
    logic [15:0] imm;
    int          sz;
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_strobes", 32'({read, write}), 0);
    chk("reset_errors", 32'({addr_error, bus_error}), 0);
    chk("reset_address", address, 0);
    chk("reset_writedata", writedata, 0);
    chk("reset_byteenable", 32'(byteenable), 0);
    chk("reset_load_data", load_data, 0);
    #20 reset_n = 1'b1;

    do_op(6'h23, 32'h1000, 16'hFFFC, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    do_op(6'h20, 32'h2000, 16'h0003, 32'h0, 32'h80112233, 0, 1'b0);
    do_op(6'h24, 32'h2000, 16'h0003, 32'h0, 32'h80112233, 1, 1'b0);
    do_op(6'h21, 32'h2000, 16'h0002, 32'h0, 32'h80112233, 0, 1'b0);
    do_op(6'h25, 32'h2000, 16'h0002, 32'h0, 32'h80112233, 2, 1'b0);
    do_op(6'h29, 32'h3000, 16'h0002, 32'h1234ABCD, 32'h0, 3, 1'b1);
    do_op(6'h23, 32'h4000, 16'h0002, 32'h0, 32'h55555555, 0, 1'b0);
    do_op(6'h23, 32'h5000, 16'h0000, 32'h0, 32'h66666666, 20, 1'b1);
    do_op(6'h3F, 32'h6000, 16'h0000, 32'h0, 32'h0, 0, 1'b0);

    // Reset in the middle of a stalled store
    @(posedge clk); #1;
    start = 1'b1; opcode = 6'h2B; base = 32'h7000; itype_immediate = 16'h0010;
    store_data = 32'hCAFEF00D; waitrequest = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("stalled_sw_write", 32'(write), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_write", 32'(write), 0);
    chk("midreset_busy_done", 32'({busy, done}), 0);
    chk("midreset_address", address, 0);
    chk("midreset_writedata", writedata, 0);
    chk("midreset_byteenable", 32'(byteenable), 0);
    chk("midreset_load_data", load_data, 0);
    model_ld = 32'd0;
    @(posedge clk); #1;
    waitrequest = 1'b0;
    reset_n = 1'b1;
    do_op(6'h23, 32'h8000, 16'h0004, 32'h0, 32'h0BADC0DE, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      op  = op_tab[$urandom_range(0, 9)];
      sz  = op_size(op);
      b   = $urandom;
      imm = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        b[1:0] = 2'b00;
        if (sz > 1) imm[0] = 1'b0;
        if (sz > 2) imm[1] = 1'b0;
      end
      do_op(op, b, imm, $urandom, $urandom, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
